// File: rtl/uart_pkg.sv
// uart_pkg: shared defaults, FSM states and strobe index helpers for the UART baud generator
package uart_pkg;
  localparam int OSR_DEF = 16;
  localparam int DIV_W_DEF = 12;
  localparam int FRAC_W_DEF = 4;
  typedef enum logic {IDLE, RUN} baud_state_t;
  localparam int SMP_EARLY_IDX = OSR_DEF / 2 - 2;
  localparam int SMP_MID_IDX = OSR_DEF / 2 - 1;
  localparam int SMP_LATE_IDX = OSR_DEF / 2;
  localparam int BIT_END_IDX = OSR_DEF - 1;
  function automatic int smp_early_idx(input int osr);
    return osr / 2 - 2;
  endfunction
  function automatic int smp_mid_idx(input int osr);
    return osr / 2 - 1;
  endfunction
  function automatic int smp_late_idx(input int osr);
    return osr / 2;
  endfunction
  function automatic int bit_end_idx(input int osr);
    return osr - 1;
  endfunction
endpackage

// File: rtl/uart_frac_acc.sv
// uart_frac_acc: fractional divisor accumulator; carry stretches the current oversample period by one clock.
// Present only when UART_BAUD_FRAC_EN is defined.
`ifdef UART_BAUD_FRAC_EN
module uart_frac_acc import uart_pkg::*; #(
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              clear,
  input  logic              step,
  input  logic [FRAC_W-1:0] frac,
  output logic              carry
);
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0] sum;
  assign sum = {1'b0, acc} + {1'b0, frac};
  assign carry = sum[FRAC_W];
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) acc <= '0;
    else if (clear) acc <= '0;
    else if (step) acc <= sum[FRAC_W-1:0];
endmodule
`endif

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: oversampling baud tick generator with early/mid/late sample strobes and bit-end strobe.
// Define UART_BAUD_FRAC_EN to enable the fractional divisor accumulator.
module uart_baud_gen import uart_pkg::*; #(
  parameter int OSR = OSR_DEF,
  parameter int DIV_W = DIV_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    en,
  input  logic                    baud_clear,
  input  logic [DIV_W-1:0]        cfg_div_int,
  input  logic [FRAC_W-1:0]       cfg_div_frac,
  output logic                    os_tick,
  output logic                    smp_early,
  output logic                    smp_mid,
  output logic                    smp_late,
  output logic                    bit_tick,
  output logic [$clog2(OSR)-1:0]  os_cnt
);
  localparam int OW = $clog2(OSR);
  localparam logic [OW-1:0] EARLY = OW'(smp_early_idx(OSR));
  localparam logic [OW-1:0] MID = OW'(smp_mid_idx(OSR));
  localparam logic [OW-1:0] LATE = OW'(smp_late_idx(OSR));
  localparam logic [OW-1:0] LAST = OW'(bit_end_idx(OSR));
  baud_state_t state, state_nx;
  logic [DIV_W-1:0] cnt, cnt_nx, d;
  logic [OW-1:0] os_cnt_nx;
  logic load, reload, c;
  assign d = (cfg_div_int < DIV_W'(2)) ? DIV_W'(2) : cfg_div_int;
`ifdef UART_BAUD_FRAC_EN
  uart_frac_acc #(.FRAC_W(FRAC_W)) u_frac_acc (
    .clk   (clk),
    .rst_b (rst_b),
    .clear (load || !en),
    .step  (reload),
    .frac  (cfg_div_frac),
    .carry (c)
  );
`else
  logic unused_frac;
  assign unused_frac = ^cfg_div_frac;
  assign c = 1'b0;
`endif
  // baud_clear wins over a coincident reload, so its strobe is dropped
  always_comb begin
    load = en && (state == IDLE || baud_clear);
    reload = en && state == RUN && !baud_clear && cnt == '0;
    state_nx = en ? RUN : IDLE;
    cnt_nx = load ? d - DIV_W'(1) :
             reload ? d - DIV_W'(1) + DIV_W'(c) :
             (en && state == RUN) ? cnt - DIV_W'(1) : '0;
    os_cnt_nx = (load || !en) ? '0 :
                reload ? ((os_cnt == LAST) ? '0 : os_cnt + OW'(1)) : os_cnt;
  end
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      state <= IDLE;
      cnt <= '0;
      os_cnt <= '0;
      os_tick <= 1'b0;
      smp_early <= 1'b0;
      smp_mid <= 1'b0;
      smp_late <= 1'b0;
      bit_tick <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      os_cnt <= os_cnt_nx;
      os_tick <= reload;
      smp_early <= reload && os_cnt == EARLY;
      smp_mid <= reload && os_cnt == MID;
      smp_late <= reload && os_cnt == LATE;
      bit_tick <= reload && os_cnt == LAST;
    end
endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen: directed self-checking bench for uart_baud_gen (OSR=16 and OSR=8 instances sharing inputs).
module tb_uart_baud_gen;
  import uart_pkg::*;
`ifdef UART_BAUD_FRAC_EN
  localparam int EXP_BIT = 434;
  localparam int EXP28 = 2;
`else
  localparam int EXP_BIT = 432;
  localparam int EXP28 = 0;
`endif
  logic clk, rst_b, en, baud_clear;
  logic [11:0] cfg_div_int;
  logic [3:0] cfg_div_frac;
  logic t16, e16, m16, l16, b16;
  logic [3:0] oc16;
  logic t8, e8, m8, l8, b8;
  logic [2:0] oc8;
  int vectors = 0;
  int errors = 0;

  uart_baud_gen #(.OSR(16), .DIV_W(12), .FRAC_W(4)) u16 (
    .clk(clk), .rst_b(rst_b), .en(en), .baud_clear(baud_clear),
    .cfg_div_int(cfg_div_int), .cfg_div_frac(cfg_div_frac),
    .os_tick(t16), .smp_early(e16), .smp_mid(m16), .smp_late(l16),
    .bit_tick(b16), .os_cnt(oc16)
  );
  uart_baud_gen #(.OSR(8), .DIV_W(12), .FRAC_W(4)) u8 (
    .clk(clk), .rst_b(rst_b), .en(en), .baud_clear(baud_clear),
    .cfg_div_int(cfg_div_int), .cfg_div_frac(cfg_div_frac),
    .os_tick(t8), .smp_early(e8), .smp_mid(m8), .smp_late(l8),
    .bit_tick(b8), .os_cnt(oc8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic go_idle;
    en = 1'b0;
    baud_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_b = 1'b0;
    en = 1'b0;
    baud_clear = 1'b0;
    cfg_div_int = 12'd0;
    cfg_div_frac = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({t16, e16, m16, l16, b16, oc16} !== 9'd0) begin
      errors++;
      $display("FAIL reset_u16: got %b want %b", {t16, e16, m16, l16, b16, oc16}, 9'd0);
    end
    vectors++;
    if ({t8, e8, m8, l8, b8, oc8} !== 8'd0) begin
      errors++;
      $display("FAIL reset_u8: got %b want %b", {t8, e8, m8, l8, b8, oc8}, 8'd0);
    end
    rst_b = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_rate;
    int ot[$];
    int bi[$];
    int sp, n28, n27;
    go_idle();
    cfg_div_int = 12'd27;
    cfg_div_frac = 4'd2;
    en = 1'b1;
    for (int e = 0; e < 1800; e++) begin
      @(posedge clk);
      #1;
      if (t16) begin
        ot.push_back(e);
        if (b16) bi.push_back(ot.size() - 1);
      end
    end
    vectors++;
    if (bi.size() < 4) begin
      errors++;
      $display("FAIL rate_bit_count: got %0d bit_ticks want 4", bi.size());
    end
    for (int k = 0; k + 1 < bi.size(); k++) begin
      sp = ot[bi[k+1]] - ot[bi[k]];
      n28 = 0;
      n27 = 0;
      for (int j = bi[k] + 1; j <= bi[k+1]; j++) begin
        if (ot[j] - ot[j-1] == 28) n28++;
        else if (ot[j] - ot[j-1] == 27) n27++;
      end
      vectors++;
      if (sp !== EXP_BIT) begin
        errors++;
        $display("FAIL rate_bit_spacing[%0d]: got %0d want %0d", k, sp, EXP_BIT);
      end
      vectors++;
      if (n28 !== EXP28) begin
        errors++;
        $display("FAIL rate_long_periods[%0d]: got %0d want %0d", k, n28, EXP28);
      end
      vectors++;
      if (n27 !== 16 - EXP28) begin
        errors++;
        $display("FAIL rate_short_periods[%0d]: got %0d want %0d", k, n27, 16 - EXP28);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_strobes;
    logic tk;
    int i8, i16;
    logic [7:0] x8;
    logic [8:0] x16;
    go_idle();
    cfg_div_int = 12'd4;
    cfg_div_frac = 4'd0;
    en = 1'b1;
    for (int n = 0; n <= 70; n++) begin
      @(posedge clk);
      #1;
      tk = n > 0 && n % 4 == 0;
      i8 = (n / 4 + 7) % 8;
      i16 = (n / 4 + 15) % 16;
      x8 = {tk, tk && i8 == 2, tk && i8 == 3, tk && i8 == 4, tk && i8 == 7, 3'((n / 4) % 8)};
      x16 = {tk, tk && i16 == 6, tk && i16 == 7, tk && i16 == 8, tk && i16 == 15, 4'((n / 4) % 16)};
      vectors++;
      if ({t8, e8, m8, l8, b8, oc8} !== x8) begin
        errors++;
        $display("FAIL strobe_u8 n=%0d: got %b want %b", n, {t8, e8, m8, l8, b8, oc8}, x8);
      end
      vectors++;
      if ({t16, e16, m16, l16, b16, oc16} !== x16) begin
        errors++;
        $display("FAIL strobe_u16 n=%0d: got %b want %b", n, {t16, e16, m16, l16, b16, oc16}, x16);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_clear;
    int n;
    logic [4:0] x;
    go_idle();
    cfg_div_int = 12'd5;
    cfg_div_frac = 4'd0;
    en = 1'b1;
    n = 0;
    for (int e = 0; e < 80; e++) begin
      baud_clear = (e == 48 || e == 58);
      @(posedge clk);
      #1;
      n = (e == 0 || e == 48 || e == 58) ? 0 : n + 1;
      x = {n > 0 && n % 5 == 0, 4'((n / 5) % 16)};
      vectors++;
      if ({t16, oc16} !== x) begin
        errors++;
        $display("FAIL clear e=%0d: got %b want %b", e, {t16, oc16}, x);
      end
    end
    baud_clear = 1'b0;
    en = 1'b0;
  endtask

  task automatic test_en_drop;
    int n;
    logic [4:0] x;
    go_idle();
    cfg_div_int = 12'd3;
    cfg_div_frac = 4'd0;
    n = 0;
    for (int e = 0; e < 26; e++) begin
      en = (e != 10);
      @(posedge clk);
      #1;
      n = (e == 0 || e == 11) ? 0 : n + 1;
      x = (e == 10) ? 5'd0 : {n > 0 && n % 3 == 0, 4'((n / 3) % 16)};
      vectors++;
      if ({t16, oc16} !== x) begin
        errors++;
        $display("FAIL en_drop e=%0d: got %b want %b", e, {t16, oc16}, x);
      end
      if (e == 10) begin
        vectors++;
        if (u16.cnt !== 12'd0 || u16.state !== IDLE) begin
          errors++;
          $display("FAIL en_drop_idle: got cnt=%0d state=%0d want cnt=0 state=%0d", u16.cnt, u16.state, IDLE);
        end
      end
    end
    en = 1'b0;
  endtask

  task automatic test_clamp_reset;
    logic [4:0] x;
    go_idle();
    cfg_div_int = 12'd0;
    cfg_div_frac = 4'd0;
    en = 1'b1;
    for (int n = 0; n <= 20; n++) begin
      @(posedge clk);
      #1;
      x = {n > 0 && n % 2 == 0, 4'((n / 2) % 16)};
      vectors++;
      if ({t16, oc16} !== x) begin
        errors++;
        $display("FAIL clamp n=%0d: got %b want %b", n, {t16, oc16}, x);
      end
    end
    rst_b = 1'b0;
    #2;
    vectors++;
    if ({t16, e16, m16, l16, b16, oc16, t8, e8, m8, l8, b8, oc8} !== 17'd0) begin
      errors++;
      $display("FAIL async_reset: got %b want %b", {t16, e16, m16, l16, b16, oc16, t8, e8, m8, l8, b8, oc8}, 17'd0);
    end
    en = 1'b0;
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk);
      #1;
      vectors++;
      if ({t16, oc16, t8, oc8} !== 9'd0) begin
        errors++;
        $display("FAIL post_reset_idle n=%0d: got %b want %b", n, {t16, oc16, t8, oc8}, 9'd0);
      end
    end
    en = 1'b1;
    for (int n = 0; n <= 8; n++) begin
      @(posedge clk);
      #1;
      x = {n > 0 && n % 2 == 0, 4'((n / 2) % 16)};
      vectors++;
      if ({t16, oc16} !== x) begin
        errors++;
        $display("FAIL restart n=%0d: got %b want %b", n, {t16, oc16}, x);
      end
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rate();
    test_strobes();
    test_clear();
    test_en_drop();
    test_clamp_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
